// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a one-entry skid buffer on a valid/ready handshake.
// Define DEC_ILLEGAL_CHECK_EN to build the illegal-encoding detector; otherwise illegal is tied to 0.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       op,
    output logic [4:0]       rd,
    output logic [2:0]       f3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       f7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_type,
    output logic [XLEN-1:0]  pc_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [6:0]       op;
        logic [4:0]       rd;
        logic [2:0]       f3;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [6:0]       f7;
        logic [XLEN-1:0]  imm;
        imm_type_e        imm_type;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t    dec;
    entry_t    or_q;
    entry_t    sk_q;
    logic      or_valid;
    logic      sk_valid;
    logic      in_fire;
    imm_type_e fmt;
    logic      ill;
    logic [31:0] imm32;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        fmt   = IMM_NONE;
        ill   = 1'b0;
        imm32 = '0;

        case (instr[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: fmt = IMM_I;
            7'b0011011:             fmt = (XLEN == 64) ? IMM_I : IMM_NONE;
            7'b0100011:             fmt = IMM_S;
            7'b1100011:             fmt = IMM_B;
            7'b0110111, 7'b0010111: fmt = IMM_U;
            7'b1101111:             fmt = IMM_J;
            default:                fmt = IMM_NONE;
        endcase

`ifdef DEC_ILLEGAL_CHECK_EN
        // R-type opcodes are legal but carry no immediate.
        ill = (instr[1:0] != 2'b11) ||
              !((fmt != IMM_NONE) || (instr[6:0] == 7'b0110011) ||
                ((XLEN == 64) && (instr[6:0] == 7'b0111011)));
        if (ill) fmt = IMM_NONE;
`endif

        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        dec.op       = instr[6:0];
        dec.rd       = instr[11:7];
        dec.f3       = instr[14:12];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.f7       = instr[31:25];
        dec.imm      = XLEN'($signed(imm32));
        dec.imm_type = fmt;
        dec.pc       = pc_in;
        dec.tag      = tag_in;
        dec.illegal  = ill;
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = !sk_valid;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            // NOTE: the data registers are reset as well so every data output reads 0 after reset.
            or_q     <= '0;
            sk_q     <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (or_valid && out_ready && sk_valid) begin
            or_q     <= sk_q;
            sk_valid <= 1'b0;
        end else if (!or_valid || out_ready) begin
            or_valid <= in_fire;
            if (in_fire) or_q <= dec;
        end else if (in_fire) begin
            sk_q     <= dec;
            sk_valid <= 1'b1;
        end
    end

    assign out_valid = or_valid;
    assign op        = or_q.op;
    assign rd        = or_q.rd;
    assign f3        = or_q.f3;
    assign rs1       = or_q.rs1;
    assign rs2       = or_q.rs2;
    assign f7        = or_q.f7;
    assign imm       = or_q.imm;
    assign imm_type  = or_q.imm_type;
    assign pc_out    = or_q.pc;
    assign tag_out   = or_q.tag;
    assign illegal   = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: one XLEN=32 and one XLEN=64 instance share the stimulus,
// outputs are compared each cycle against a queue-based reference of accepted entries.
module tb_decode_stage;

    localparam int TAG_W = 4;
`ifdef DEC_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, out_ready;
    logic [31:0]      instr, pc;
    logic [TAG_W-1:0] tag;
    logic [63:0]      pc_w;
    assign pc_w = {~pc, pc};

    logic             in_ready, out_valid, illegal;
    logic [6:0]       op, f7;
    logic [4:0]       rd, rs1, rs2;
    logic [2:0]       f3, imm_type;
    logic [31:0]      imm, pc_out;
    logic [TAG_W-1:0] tag_out;

    logic             w_in_ready, w_out_valid, w_illegal;
    logic [6:0]       w_op, w_f7;
    logic [4:0]       w_rd, w_rs1, w_rs2;
    logic [2:0]       w_f3, w_imm_type;
    logic [63:0]      w_imm, w_pc_out;
    logic [TAG_W-1:0] w_tag_out;

    decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc), .tag_in(tag), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .rd(rd), .f3(f3), .rs1(rs1), .rs2(rs2), .f7(f7), .imm(imm),
        .imm_type(imm_type), .pc_out(pc_out), .tag_out(tag_out), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .instr(instr), .pc_in(pc_w), .tag_in(tag), .out_valid(w_out_valid), .out_ready(out_ready),
        .op(w_op), .rd(w_rd), .f3(w_f3), .rs1(w_rs1), .rs2(w_rs2), .f7(w_f7), .imm(w_imm),
        .imm_type(w_imm_type), .pc_out(w_pc_out), .tag_out(w_tag_out), .illegal(w_illegal)
    );

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic bit ill_of(input logic [31:0] i, input int xlen);
`ifdef DEC_ILLEGAL_CHECK_EN
        logic [6:0] o;
        bit known;
        o = i[6:0];
        known = (o inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33}) ||
                (xlen == 64 && (o inside {7'h1B, 7'h3B}));
        return (i[1:0] != 2'b11) || !known;
`else
        return (i[0] && !i[0]) || (xlen < 0);
`endif
    endfunction

    function automatic int fmt_of(input logic [31:0] i, input int xlen);
        int f;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: f = 1;
            7'h1B:                      f = (xlen == 64) ? 1 : 0;
            7'h23:                      f = 2;
            7'h63:                      f = 3;
            7'h37, 7'h17:               f = 4;
            7'h6F:                      f = 5;
            default:                    f = 0;
        endcase
        if (ill_of(i, xlen)) f = 0;
        return f;
    endfunction

    // Immediate as a signed integer value, built from bit weights rather than concatenation.
    function automatic longint model_imm(input logic [31:0] i, input int xlen);
        longint v;
        v = 0;
        case (fmt_of(i, xlen))
            1: begin
                v = longint'(i[31:20]);
                if (v >= 2048) v -= 4096;
            end
            2: begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3: begin
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                    longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            4: begin
                v = longint'(i[31:12]) * 4096;
                if (v >= 64'sh80000000) v -= 64'sh100000000;
            end
            5: begin
                v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                    longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic cmp_out(input ent_t e);
        logic [63:0] v32, v64;
        v32 = model_imm(e.instr, 32);
        v64 = model_imm(e.instr, 64);
        check("fields", {op, rd, f3, rs1, rs2, f7},
              {e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25]});
        check("imm", imm, {32'h0, v32[31:0]});
        check("imm_type", imm_type, fmt_of(e.instr, 32));
        check("pc_tag", {pc_out, tag_out}, {e.pc, e.tag});
        check("illegal", illegal, ill_of(e.instr, 32));
        check("w_fields", {w_op, w_rd, w_f3, w_rs1, w_rs2, w_f7}, {e.instr[6:0], e.instr[11:7],
              e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25]});
        check("w_imm", w_imm, v64);
        check("w_imm_type", w_imm_type, fmt_of(e.instr, 64));
        check("w_pc", w_pc_out, {~e.pc, e.pc});
        check("w_tag_ill", {w_tag_out, w_illegal}, {e.tag, ill_of(e.instr, 64)});
    endtask

    // Check mid-cycle, then advance one edge and update the reference queue.
    task automatic cycle();
        bit   in_fire, out_fire;
        ent_t cur;
        @(negedge clk);
        check("in_ready", in_ready, q.size() < 2);
        check("w_in_ready", w_in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        check("w_out_valid", w_out_valid, q.size() > 0);
        if (q.size() > 0) cmp_out(q[0]);
        in_fire  = in_valid && (q.size() < 2);
        out_fire = out_ready && (q.size() > 0);
        cur      = '{instr: instr, pc: pc, tag: tag};
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(cur);
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        tag      = t;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14];
        logic [31:0] r;
        int k;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00, 7'h7F};
        r = $urandom();
        k = $urandom_range(0, 15);
        if (k < 14) r[6:0] = ops[k];
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        offer(32'hFFF00093, 32'h0000_1000, 4'h1);

        // Reset held two cycles with in_valid high.
        @(posedge clk); #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_imm", imm, 64'h0);
        cycle();
        check("rst_valid2", out_valid, 1'b0);
        check("rst_w_imm", w_imm, 64'h0);
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        check("post_rst_ready", in_ready, 1'b1);

        // Immediate formats, one-cycle latency.
        offer(32'hFFF00093, 32'h0000_2000, 4'h2);
        cycle();
        check("lat_valid", out_valid, 1'b1);
        check("i_type", imm_type, 3'd1);
        check("i_imm", imm, 64'hFFFF_FFFF);
        check("i_rd", rd, 5'd1);
        offer(32'hFE000EE3, 32'h0000_2004, 4'h3);
        cycle();
        check("b_type", imm_type, 3'd3);
        check("b_imm", imm, 64'hFFFF_FFFC);
        offer(32'h800000EF, 32'h0000_2008, 4'h4);
        cycle();
        check("j_type", imm_type, 3'd5);
        check("j_imm", imm, 64'hFFF0_0000);
        offer(32'h800002B7, 32'h0000_200C, 4'h5);
        cycle();
        check("u_w_type", w_imm_type, 3'd4);
        check("u_w_imm", w_imm, 64'hFFFF_FFFF_8000_0000);
        check("u_imm", imm, 64'h8000_0000);
        offer(32'h0000_0000, 32'h0000_2010, 4'h6);
        cycle();
        check("zero_illegal", illegal, ILL_EN);
        check("zero_type", imm_type, 3'd0);
        in_valid = 1'b0;
        cycle();

        // Back-pressure: A in OR, B in SK, C held upstream, then drain in order.
        out_ready = 1'b0;
        offer(32'h0010_0093, 32'h0000_3000, 4'hA);
        cycle();
        offer(32'h0020_0113, 32'h0000_3004, 4'hB);
        cycle();
        check("bp_ready_low", in_ready, 1'b0);
        check("bp_head", pc_out, 64'h3000);
        offer(32'h0030_0193, 32'h0000_3008, 4'hC);
        cycle();
        check("bp_hold", pc_out, 64'h3000);
        out_ready = 1'b1;
        cycle();
        check("bp_second", pc_out, 64'h3004);
        check("bp_ready_back", in_ready, 1'b1);
        cycle();
        check("bp_third", pc_out, 64'h3008);
        in_valid = 1'b0;
        cycle();
        check("bp_empty", out_valid, 1'b0);

        // Flush with both registers full and an entry on offer.
        out_ready = 1'b0;
        offer(32'h0040_0213, 32'h0000_4000, 4'hD);
        cycle();
        offer(32'h0050_0293, 32'h0000_4004, 4'hE);
        cycle();
        offer(32'h0060_0313, 32'h0000_4008, 4'hF);
        flush = 1'b1;
        cycle();
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        check("flush_gone", out_valid, 1'b0);

        // Reset while stalled discards both entries.
        out_ready = 1'b0;
        offer(32'h0070_0393, 32'h0000_5000, 4'h7);
        cycle();
        offer(32'h0080_0413, 32'h0000_5004, 4'h8);
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_stall_valid", out_valid, 1'b0);
        check("rst_stall_imm", imm, 64'h0);
        check("rst_stall_ready", in_ready, 1'b1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            instr     = rand_instr();
            pc        = $urandom();
            tag       = TAG_W'($urandom());
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        check("drain_empty", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
